// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction-fetch
// and data requesters. One access at a time, data wins by default with
// alternation under contention, and a watchdog aborts hung RAM accesses.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] BAD_WORD = DATA_W'(32'hBAD1BAD1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IACC  = 3'd1,
    DACC  = 3'd2,
    IRESP = 3'd3,
    DRESP = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_store_q, ram_store_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              err_q, err_d;
  logic              last_d_q, last_d_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              dreq;
  logic              take_i, take_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              expired;

  assign dreq    = dREN | dWEN;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign expired = (cnt_inc == CNT_W'(TIMEOUT));

  // Wait releases are combinational so the requester sees them in the response cycle itself.
  assign iwait = iREN & (state_q != IRESP);
  assign dwait = dreq & (state_q != DRESP);

  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_store = ram_store_q;
  assign iload     = iload_q;
  assign dload     = dload_q;
  assign err       = err_q;

  // State and registered outputs; reset also drops the RAM strobes asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      iload_q     <= '0;
      dload_q     <= '0;
      err_q       <= 1'b0;
      last_d_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
      err_q       <= err_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
    end
  end

  // Arbitration, access sequencing and watchdog.
  always_comb begin
    state_d     = state_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    iload_d     = iload_q;
    dload_d     = dload_q;
    err_d       = err_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    take_i      = 1'b0;
    take_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // Data has priority unless it was served last and a fetch is waiting.
        if (dreq && iREN && last_d_q) begin
          take_i = 1'b1;
        end else if (dreq) begin
          take_d = 1'b1;
        end else if (iREN) begin
          take_i = 1'b1;
        end
      end
      IACC: begin
        cnt_d = cnt_inc;
        if (ram_ready) begin
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          iload_d   = ram_load;
          state_d   = IRESP;
        end else if (expired) begin
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          iload_d   = BAD_WORD;
          err_d     = 1'b1;
          state_d   = IRESP;
        end
      end
      DACC: begin
        cnt_d = cnt_inc;
        if (ram_ready) begin
          if (ram_ren_q) begin
            dload_d = ram_load;
          end
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          state_d   = DRESP;
        end else if (expired) begin
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          dload_d   = BAD_WORD;
          err_d     = 1'b1;
          state_d   = DRESP;
        end
      end
      IRESP, DRESP: begin
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    if (take_i) begin
      state_d    = IACC;
      ram_addr_d = iaddr;
      ram_ren_d  = 1'b1;
      ram_wen_d  = 1'b0;
      cnt_d      = '0;
      last_d_d   = 1'b0;
    end

    // A simultaneous read and write request is served as a write.
    if (take_d) begin
      state_d    = DACC;
      ram_addr_d = daddr;
      cnt_d      = '0;
      last_d_d   = 1'b1;
      if (dWEN) begin
        ram_wen_d   = 1'b1;
        ram_ren_d   = 1'b0;
        ram_store_d = dstore;
      end else begin
        ram_ren_d = 1'b1;
        ram_wen_d = 1'b0;
      end
    end
  end

endmodule
